// File: rtl/shift_seq.sv
// Multi-cycle shifter, one bit position per clock; optional illegal-op flag via SHSEQ_ERR_EN.
// Latency: out_valid amt+1 cycles after accept; one request per amt+2 cycles.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_ready.
module shift_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [CNT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
`ifdef SHSEQ_ERR_EN
  ,
  output logic             out_err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [WIDTH-1:0] step_data;
  logic             step_ovf;

  // One bit-position step of the captured opcode; illegal opcodes pass through.
  always_comb begin
    step_data = data_q;
    step_ovf  = 1'b0;
    case (op_q)
      3'b000: begin
        step_data = {data_q[WIDTH-2:0], 1'b0};
        step_ovf  = data_q[WIDTH-1];
      end
      3'b001: step_data = {1'b0, data_q[WIDTH-1:1]};
      3'b010: step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      3'b011: step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      3'b100: step_data = {data_q[0], data_q[WIDTH-1:1]};
      3'b101: begin
        step_data = {data_q[WIDTH-2:0], 1'b0};
        step_ovf  = data_q[WIDTH-1] ^ data_q[WIDTH-2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      data_q <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            op_q   <= in_op;
            cnt_q  <= in_amt;
            ovf_q  <= 1'b0;
            state  <= (in_amt == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          data_q <= step_data;
          ovf_q  <= ovf_q | step_ovf;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SHSEQ_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == S_IDLE && in_valid) begin
      err_q <= in_op[2] & in_op[1];
    end
  end

  assign out_err = err_q;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_data  = data_q;
  assign out_ovf   = ovf_q;

endmodule
